// File: rtl/ysyx_22040228clint_pkg.sv
// Shared CLINT definitions: register offsets, reset values, bus width and byte-lane merge helper.
package ysyx_22040228clint_pkg;

    localparam int unsigned REGBUS = 64;
    localparam int unsigned STRB_W = REGBUS / 8;

    localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

    localparam logic [REGBUS-1:0] CLINT_MTIMECMP_RST = {REGBUS{1'b1}};

    typedef enum logic [1:0] {
        RegMsip,
        RegMtimecmp,
        RegMtime,
        RegNone
    } clint_reg_e;

    // Byte lanes with a set strobe take the new data, others keep the old value.
    function automatic logic [REGBUS-1:0] clint_merge(input logic [REGBUS-1:0] old_val,
                                                      input logic [REGBUS-1:0] wdata,
                                                      input logic [STRB_W-1:0] wmask);
        logic [REGBUS-1:0] res;
        for (int i = 0; i < int'(STRB_W); i++) begin
            res[8*i +: 8] = wmask[i] ? wdata[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ysyx_22040228clint_mtime.sv
// CLINT machine timer: prescaler, 64-bit mtime counter and byte-masked software write merge.
module ysyx_22040228clint_mtime
    import ysyx_22040228clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              halt_i,
    input  logic              wen_i,
    input  logic [REGBUS-1:0] wdata_i,
    input  logic [STRB_W-1:0] wmask_i,
    output logic [REGBUS-1:0] mtime_o,
    output logic [REGBUS-1:0] mtime_d_o
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);

    logic [PW-1:0]     presc_q, presc_d;
    logic [REGBUS-1:0] mtime_q, mtime_d;
    logic              tick;

    always_comb begin
        tick    = ~halt_i & (presc_q == PrescMax);
        presc_d = presc_q;
        if (!halt_i) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
        // A software write overrides the increment; the prescaler keeps counting.
        mtime_d = mtime_q;
        if (wen_i) begin
            mtime_d = clint_merge(mtime_q, wdata_i, wmask_i);
        end else if (tick) begin
            mtime_d = mtime_q + REGBUS'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
            mtime_q <= '0;
        end else begin
            presc_q <= presc_d;
            mtime_q <= mtime_d;
        end
    end

    assign mtime_o   = mtime_q;
    assign mtime_d_o = mtime_d;

endmodule

// File: rtl/ysyx_22040228clint.sv
// Core-local interruptor: msip/mtimecmp/mtime on a single-outstanding valid/ready MMIO port.
// Define CLINT_STOP_IN_DEBUG_EN to add dbg_halt_i, which freezes the timer while asserted.
module ysyx_22040228clint
    import ysyx_22040228clint_pkg::*;
#(
    parameter logic [63:0] CLINT_BASE = 64'h0200_0000,
    parameter int unsigned TICK_DIV   = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
`ifdef CLINT_STOP_IN_DEBUG_EN
    input  logic              dbg_halt_i,
`endif
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_wen_i,
    input  logic [REGBUS-1:0] req_addr_i,
    input  logic [REGBUS-1:0] req_wdata_i,
    input  logic [STRB_W-1:0] req_wmask_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [REGBUS-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              tmr_intr_ena_o,
    output logic              sft_intr_ena_o
);

    logic              halt;
    logic              accept, wr;
    clint_reg_e        sel;
    logic              msip_q, msip_d;
    logic [REGBUS-1:0] mtimecmp_q, mtimecmp_d;
    logic [REGBUS-1:0] mtime, mtime_d;
    logic              mtime_wen;
    logic              rsp_valid_q, rsp_valid_d;
    logic [REGBUS-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              tmr_q, tmr_d;

`ifdef CLINT_STOP_IN_DEBUG_EN
    assign halt = dbg_halt_i;
`else
    assign halt = 1'b0;
`endif

    assign req_ready_o = ~rsp_valid_q | rsp_ready_i;
    assign accept      = req_valid_i & req_ready_o;
    assign wr          = accept & req_wen_i;

    // Unmapped or misaligned accesses decode to RegNone and never touch state.
    always_comb begin
        sel = RegNone;
        if ((req_addr_i[63:16] == CLINT_BASE[63:16]) && (req_addr_i[2:0] == 3'b000)) begin
            case (req_addr_i[15:0])
                CLINT_MSIP_OFF:     sel = RegMsip;
                CLINT_MTIMECMP_OFF: sel = RegMtimecmp;
                CLINT_MTIME_OFF:    sel = RegMtime;
                default:            sel = RegNone;
            endcase
        end
    end

    assign mtime_wen = wr & (sel == RegMtime);

    ysyx_22040228clint_mtime #(
        .TICK_DIV(TICK_DIV)
    ) u_mtime (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .halt_i   (halt),
        .wen_i    (mtime_wen),
        .wdata_i  (req_wdata_i),
        .wmask_i  (req_wmask_i),
        .mtime_o  (mtime),
        .mtime_d_o(mtime_d)
    );

    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        if (wr && (sel == RegMsip) && req_wmask_i[0]) begin
            msip_d = req_wdata_i[0];
        end
        if (wr && (sel == RegMtimecmp)) begin
            mtimecmp_d = clint_merge(mtimecmp_q, req_wdata_i, req_wmask_i);
        end
    end

    assign tmr_d = (mtime_d >= mtimecmp_d);

    // Response holds until consumed; reads see register values before this edge's update.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = (sel == RegNone);
            rsp_rdata_d = '0;
            if (!req_wen_i) begin
                case (sel)
                    RegMsip:     rsp_rdata_d = {{(REGBUS-1){1'b0}}, msip_q};
                    RegMtimecmp: rsp_rdata_d = mtimecmp_q;
                    RegMtime:    rsp_rdata_d = mtime;
                    default:     rsp_rdata_d = '0;
                endcase
            end
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            msip_q      <= 1'b0;
            mtimecmp_q  <= CLINT_MTIMECMP_RST;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            tmr_q       <= 1'b0;
        end else begin
            msip_q      <= msip_d;
            mtimecmp_q  <= mtimecmp_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            tmr_q       <= tmr_d;
        end
    end

    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_rdata_o    = rsp_rdata_q;
    assign rsp_err_o      = rsp_err_q;
    assign tmr_intr_ena_o = tmr_q;
    assign sft_intr_ena_o = msip_q;

endmodule
